npc_pc_ctrl: RTL
================

# npc_pc_ctrl

Sequential next-PC and program-counter controller: the parametrised successor to the combinational next-PC block. It owns the PC register and evaluates six branch conditions. It handles jump, jump-register, exception entry/return (EPC, cause, exception mode) and fetch stalls, and counts retired instructions. It sits between the control unit/ALU flags and the instruction-memory address port.

## Interface
- ADDR_W, 32, byte-address width, legal range 28..32; PC held word-addressed as [ADDR_W-1:2]
- RESET_VEC, 32'h0000_3000, byte address loaded on reset
- EXC_VEC, 32'h0000_4180, byte address of the exception handler
- CNT_W, 32, retired-instruction counter width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- I_Ready  in  1  instruction memory accepts/returns current address
- Stall  in  1  pipeline hold request
- Jump  in  1  J/JAL: absolute target
- JumpReg  in  1  JR/JALR: register target
- Branch  in  1  conditional branch instruction
- BrCond  in  3  condition code (npc_pkg)
- Zero, Sign  in  1 each  ALU flags of the compare
- Imm16  in  16  branch offset, words
- J_Target  in  26  jump field
- RegTarget  in  ADDR_W  byte target for JumpReg
- ExcReq  in  1  external exception/interrupt request
- Eret  in  1  return from exception
- I_Addr  out  ADDR_W-2  current PC, registered
- Next_I_Addr  out  ADDR_W-2  address loaded at next advance, combinational
- EPC  out  ADDR_W-2  saved exception PC
- ExcMode  out  1  in handler
- Cause  out  2  last exception cause
- RetireCnt  out  CNT_W  instructions retired

## Operation
- adv = I_Ready & ~Stall. PC, EPC, ExcMode, Cause and RetireCnt change only when adv=1. Otherwise all hold. The control inputs are stable for the whole stall, since they derive from the held instruction.
- PC1 = I_Addr + 1. B_Addr = PC1 + sext(Imm16). J_Addr = {I_Addr[ADDR_W-1:28], J_Target}. R_Addr = RegTarget[ADDR_W-1:2]. All arithmetic is modulo 2^(ADDR_W-2), with silent wrap.
- Branch taken = Branch & cond, where cond per BrCond: 0 BEQ Zero; 1 BNE ~Zero; 2 BLEZ Sign|Zero; 3 BGTZ ~Sign&~Zero; 4 BLTZ Sign; 5 BGEZ ~Sign; 6,7 never taken.
- Misalign = JumpReg & (RegTarget[1:0] != 0).
- Next_I_Addr priority:
  - ExcReq | Misalign → EXC_VEC[ADDR_W-1:2]
  - Eret & ExcMode → EPC
  - Jump → J_Addr
  - JumpReg → R_Addr
  - taken → B_Addr
  - else PC1
- Eret with ExcMode=0 is a no-op and yields PC1.
- Exception entry on adv: the exception is taken when ExcReq or Misalign is asserted.
  - If ExcMode=0: EPC ← I_Addr, ExcMode ← 1, Cause ← 0 for ExcReq, 1 for Misalign. ExcReq wins if both are asserted.
  - If ExcMode=1 (nested): the PC still redirects to EXC_VEC, but EPC is not overwritten. Cause is updated.
- Eret & ExcMode on adv, with no exception pending: ExcMode ← 0. EPC and Cause are retained.
- RetireCnt increments by 1 on every adv, including redirects, and wraps to 0.

## Timing
- Reset (async assert, any time, including mid-stall):
  - I_Addr = RESET_VEC[ADDR_W-1:2]
  - EPC = 0
  - ExcMode = 0
  - Cause = 0
  - RetireCnt = 0
- First advance is possible on the first edge after rst_n deasserts.
- Next_I_Addr reflects the inputs with zero latency. I_Addr takes that value one edge after adv.
- Stall and I_Ready are equivalent holds. adv on consecutive cycles gives one instruction per cycle.

## Structure
- Package npc_pkg: BrCond codes (BR_EQ..BR_GEZ), cause codes (CAUSE_INT=0, CAUSE_ADEL=1), default vector constants.
- One sub-module, branch_cond_eval (BrCond, Zero, Sign → cond), purely combinational. PC/EPC/counter registers stay in the top.

## Test plan
Byte addresses below mean {I_Addr,2'b00}.
- Reset and sequential run: reset, then 3 adv cycles → 0x3000, 0x3004, 0x3008, 0x300C; RetireCnt=3. Hold Stall=1 for 2 cycles → PC stays 0x300C and the counter stays at 3.
- Branches: at PC 0x3010, BrCond=BNE, Zero=0, Imm16=0xFFFC → 0x3004. Same with Zero=1 → 0x3014. BrCond=7 with Branch=1 → 0x3014.
- Jumps: at 0x3020, Jump with J_Target=0x0000800 → 0x2000. JumpReg with RegTarget=0x3400 → 0x3400.
- Misaligned JR: at 0x3030, RegTarget=0x3402 → PC 0x4180, EPC 0x3030, Cause=1, ExcMode=1. Eret on the next adv → PC 0x3030, ExcMode=0.
- Nested and no-op cases: ExcReq at 0x3040, then ExcReq again at 0x4184 → EPC stays 0x3040, Cause=0. Eret with ExcMode=0 at 0x3050 → 0x3054.
- Async reset mid-stall: rst_n low while Stall=1 → all outputs at reset values immediately, without waiting for an edge.

Source files
------------

// File: rtl/npc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | npc_pkg: branch condition codes, exception causes, vector defaults |
// | Revision: 1.0                                                      |
// +------------------------------------------------------------------+
package npc_pkg;

    typedef enum logic [2:0] {
        BR_EQ  = 3'd0,
        BR_NE  = 3'd1,
        BR_LEZ = 3'd2,
        BR_GTZ = 3'd3,
        BR_LTZ = 3'd4,
        BR_GEZ = 3'd5
    } br_cond_e;

    localparam logic [1:0]  CAUSE_INT     = 2'd0;
    localparam logic [1:0]  CAUSE_ADEL    = 2'd1;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_4180;

endpackage
`default_nettype wire

// File: rtl/branch_cond_eval.sv
`default_nettype none
// +------------------------------------------------------------------+
// | branch_cond_eval: decodes a branch condition code against flags    |
// | Revision: 1.0                                                      |
// +------------------------------------------------------------------+
module branch_cond_eval
    import npc_pkg::*;
(
    input  logic [2:0] br_cond,
    input  logic       zero,
    input  logic       sign,
    output logic       cond
);

    always_comb begin
        cond = 1'b0;
        case (br_cond)
            BR_EQ:   cond = zero;
            BR_NE:   cond = ~zero;
            BR_LEZ:  cond = sign | zero;
            BR_GTZ:  cond = ~sign & ~zero;
            BR_LTZ:  cond = sign;
            BR_GEZ:  cond = ~sign;
            default: cond = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/npc_pc_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | npc_pc_ctrl: PC register, next-PC selection, exception entry/return |
// | Revision: 1.0                                                      |
// +------------------------------------------------------------------+
module npc_pc_ctrl
    import npc_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
    parameter logic [31:0] EXC_VEC   = DEF_EXC_VEC,
    parameter int          CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              I_Ready,
    input  logic              Stall,
    input  logic              Jump,
    input  logic              JumpReg,
    input  logic              Branch,
    input  logic [2:0]        BrCond,
    input  logic              Zero,
    input  logic              Sign,
    input  logic [15:0]       Imm16,
    input  logic [25:0]       J_Target,
    input  logic [ADDR_W-1:0] RegTarget,
    input  logic              ExcReq,
    input  logic              Eret,
    output logic [ADDR_W-3:0] I_Addr,
    output logic [ADDR_W-3:0] Next_I_Addr,
    output logic [ADDR_W-3:0] EPC,
    output logic              ExcMode,
    output logic [1:0]        Cause,
    output logic [CNT_W-1:0]  RetireCnt
);

    localparam int              PC_W   = ADDR_W - 2;
    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  r_epc;
    logic             r_exc_mode;
    logic [1:0]       r_cause;
    logic [CNT_W-1:0] r_cnt;

    logic             w_adv;
    logic             w_cond;
    logic             w_taken;
    logic             w_misalign;
    logic             w_exc;
    logic             w_eret;
    logic [PC_W-1:0]  w_pc1;
    logic [PC_W-1:0]  w_b_addr;
    logic [PC_W-1:0]  w_j_addr;
    logic [PC_W-1:0]  w_r_addr;
    logic [PC_W-1:0]  w_next;

    branch_cond_eval u_cond (
        .br_cond (BrCond),
        .zero    (Zero),
        .sign    (Sign),
        .cond    (w_cond)
    );

    assign w_adv      = I_Ready & ~Stall;
    assign w_taken    = Branch & w_cond;
    assign w_misalign = JumpReg & (RegTarget[1:0] != 2'b00);
    assign w_exc      = ExcReq | w_misalign;
    assign w_eret     = Eret & r_exc_mode;

    assign w_pc1    = r_pc + PC_ONE;
    assign w_b_addr = w_pc1 + {{(PC_W-16){Imm16[15]}}, Imm16};
    assign w_r_addr = RegTarget[ADDR_W-1:2];

    // At the narrowest width the 26-bit jump field covers the whole PC.
    if (ADDR_W > 28) begin : g_jaddr_region
        assign w_j_addr = {r_pc[PC_W-1:26], J_Target};
    end else begin : g_jaddr_full
        assign w_j_addr = J_Target[PC_W-1:0];
    end

    always_comb begin
        w_next = w_pc1;
        if (w_exc)
            w_next = EXC_VEC[ADDR_W-1:2];
        else if (w_eret)
            w_next = r_epc;
        else if (Jump)
            w_next = w_j_addr;
        else if (JumpReg)
            w_next = w_r_addr;
        else if (w_taken)
            w_next = w_b_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_VEC[ADDR_W-1:2];
            r_epc      <= '0;
            r_exc_mode <= 1'b0;
            r_cause    <= CAUSE_INT;
            r_cnt      <= '0;
        end else if (w_adv) begin
            r_pc  <= w_next;
            r_cnt <= r_cnt + CNT_ONE;
            if (w_exc) begin
                // A nested exception keeps the original return address.
                if (!r_exc_mode)
                    r_epc <= r_pc;
                r_exc_mode <= 1'b1;
                r_cause    <= ExcReq ? CAUSE_INT : CAUSE_ADEL;
            end else if (w_eret) begin
                r_exc_mode <= 1'b0;
            end
        end
    end

    assign I_Addr      = r_pc;
    assign Next_I_Addr = w_next;
    assign EPC         = r_epc;
    assign ExcMode     = r_exc_mode;
    assign Cause       = r_cause;
    assign RetireCnt   = r_cnt;

endmodule
`default_nettype wire
